// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings, frame width, parity sense.
package uart_pkg;

  localparam int DATA_W = 8;

  // Odd parity: data bits plus parity bit carry an odd number of ones.
  localparam bit PARITY_ODD = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Parity bit the transmitter appends for a given data byte.
  function automatic logic parity_bit(input logic [DATA_W-1:0] d);
    return PARITY_ODD ? ~^d : ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous rx pin, idle-high reset,
// plus a one-cycle falling-edge detect on the synchronised line.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // Shift the raw pin through the chain; remember last synchronised value.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rx};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Reset to the idle (high) line level so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rx_s   = sync_q[SYNC_STAGES-1];
  assign fall_o = prev_q & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, odd parity, one stop bit.
// Oversampled on the system clock with a baud-cycle bit period; good bytes
// are pushed into the RX FIFO, errors are reported through sticky flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_en,
  input  logic              rx,
  input  logic [31:0]       baud,
  output logic [DATA_W-1:0] data_o,
  output logic              we_o,
  input  logic              full_i,
  input  logic              clr_err_i,
  output logic              parity_err_o,
  output logic              frame_err_o,
  output logic              overrun_o
);

  logic rx_s, fall;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx     (rx),
    .rx_s   (rx_s),
    .fall_o (fall)
  );

  // Only the low 17 bits of the divisor register are meaningful.
  logic [14:0] unused_baud_hi;
  assign unused_baud_hi = baud[31:17];

  logic [16:0] half, full;
  assign half = {1'b0, baud[16:1]} - 17'd1;
  assign full = baud[16:0] - 17'd1;

  rx_state_e         state_q, state_d;
  logic [16:0]       cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q, we_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;
  logic              perr_set, ferr_set, ovr_set;

  // Frame FSM: next state, bit counters, and the stop-bit verdict.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    data_d    = data_q;
    we_d      = 1'b0;
    perr_set  = 1'b0;
    ferr_set  = 1'b0;
    ovr_set   = 1'b0;

    if (state_q != IDLE && !rx_en) begin
      // Disabled mid-frame: drop everything silently.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (fall && rx_en) state_d = START;
        end
        START: begin
          if (cnt_q == half) begin
            cnt_d     = '0;
            bit_idx_d = '0;
            // A line back high at mid-start was a glitch, not a frame.
            state_d   = rx_s ? IDLE : DATA;
          end else begin
            cnt_d = cnt_q + 17'd1;
          end
        end
        DATA: begin
          if (cnt_q == full) begin
            cnt_d     = '0;
            shreg_d   = {rx_s, shreg_q[DATA_W-1:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_d = PARITY;
          end else begin
            cnt_d = cnt_q + 17'd1;
          end
        end
        PARITY: begin
          if (cnt_q == full) begin
            cnt_d   = '0;
            par_d   = rx_s;
            state_d = STOP;
          end else begin
            cnt_d = cnt_q + 17'd1;
          end
        end
        STOP: begin
          if (cnt_q == full) begin
            // Leave at mid-stop so a back-to-back start edge is not missed.
            cnt_d    = '0;
            state_d  = IDLE;
            perr_set = (par_q != parity_bit(shreg_q));
            if (!rx_s) begin
              ferr_set = 1'b1;
            end else if (full_i) begin
              ovr_set = 1'b1;
            end else begin
              we_d   = 1'b1;
              data_d = shreg_q;
            end
          end else begin
            cnt_d = cnt_q + 17'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Sticky flags: a set in the same cycle as a clear takes priority.
    perr_d = perr_set | (perr_q & ~clr_err_i);
    ferr_d = ferr_set | (ferr_q & ~clr_err_i);
    ovr_d  = ovr_set  | (ovr_q  & ~clr_err_i);
  end

  // All receiver state, with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      data_q    <= '0;
      we_q      <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      data_q    <= data_d;
      we_q      <= we_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign data_o       = data_q;
  assign we_o         = we_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;
  assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand sequences
// for clear, back-to-back frames, glitch, enable drop and mid-frame reset.
module tb_uart_rx;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_en = 1'b0;
  logic        rx = 1'b1;
  logic [31:0] baud = 32'd16;
  logic [7:0]  data_o;
  logic        we_o;
  logic        full_i = 1'b0;
  logic        clr_err_i = 1'b0;
  logic        parity_err_o, frame_err_o, overrun_o;

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_en        (rx_en),
    .rx           (rx),
    .baud         (baud),
    .data_o       (data_o),
    .we_o         (we_o),
    .full_i       (full_i),
    .clr_err_i    (clr_err_i),
    .parity_err_o (parity_err_o),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  logic [7:0] wq[$];

  // we_o is a one-cycle pulse; the opposite edge sees each pulse exactly once.
  always @(negedge clk) if (we_o) begin
    we_cnt++;
    wq.push_back(data_o);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (baud) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(s);
    rx = 1'b1;
  endtask

  task automatic clr_pulse();
    @(negedge clk) clr_err_i = 1'b1;
    @(negedge clk) clr_err_i = 1'b0;
  endtask

  typedef struct {
    logic [31:0] baud;
    logic [7:0]  data;
    logic        par;
    logic        stop;
    logic        full;
    logic        clr;
    int          exp_we;
    logic [7:0]  exp_data;
    logic        exp_perr;
    logic        exp_ferr;
    logic        exp_ovr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    //          baud data   p     s     full  clr   we  data   perr  ferr  ovr
    vecs[0] = '{32'd16, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'd16, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{32'd16, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'd16, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 1, 8'h55, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{32'd20, 8'h7E, 1'b1, 1'b1, 1'b1, 1'b1, 0, 8'h00, 1'b0, 1'b0, 1'b1};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_data", data_o, 8'h00);
    chk("rst_we", we_o, 0);
    chk("rst_flags", {parity_err_o, frame_err_o, overrun_o}, 3'b000);
    rst_n = 1'b1;
    rx_en = 1'b1;
    repeat (4) @(negedge clk);

    // Single-frame table.
    for (int v = 0; v < 5; v++) begin
      baud   = vecs[v].baud;
      full_i = vecs[v].full;
      if (vecs[v].clr) clr_pulse();
      we_cnt = 0;
      wq.delete();
      send_frame(vecs[v].data, vecs[v].par, vecs[v].stop);
      repeat (2 * baud) @(negedge clk);
      chk($sformatf("v%0d_we", v), we_cnt, vecs[v].exp_we);
      if (vecs[v].exp_we == 1 && wq.size() == 1)
        chk($sformatf("v%0d_data", v), wq[0], vecs[v].exp_data);
      chk($sformatf("v%0d_perr", v), parity_err_o, vecs[v].exp_perr);
      chk($sformatf("v%0d_ferr", v), frame_err_o, vecs[v].exp_ferr);
      chk($sformatf("v%0d_ovr", v), overrun_o, vecs[v].exp_ovr);
      if (v == 1) begin
        clr_pulse();
        chk("perr_cleared", parity_err_o, 0);
      end
    end
    full_i = 1'b0;

    // Back-to-back frames at baud 20, one stop bit each.
    clr_pulse();
    we_cnt = 0;
    wq.delete();
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    repeat (40) @(negedge clk);
    chk("b2b_we", we_cnt, 2);
    if (wq.size() == 2) begin
      chk("b2b_d0", wq[0], 8'h00);
      chk("b2b_d1", wq[1], 8'hFF);
    end
    chk("b2b_flags", {parity_err_o, frame_err_o, overrun_o}, 3'b000);

    // Short low glitch must not start a frame.
    baud = 32'd16;
    we_cnt = 0;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (12) @(negedge clk);
    chk("glitch_state", dut.state_q, IDLE);
    repeat (200) @(negedge clk);
    chk("glitch_we", we_cnt, 0);
    chk("glitch_flags", {parity_err_o, frame_err_o, overrun_o}, 3'b000);

    // Drop rx_en during DATA.
    we_cnt = 0;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    chk("en_in_data", dut.state_q, DATA);
    rx_en = 1'b0;
    @(negedge clk);
    chk("en_abort_idle", dut.state_q, IDLE);
    for (int i = 0; i < 8; i++) drive_bit(1'b0);
    rx = 1'b1;
    repeat (32) @(negedge clk);
    rx_en = 1'b1;
    repeat (4) @(negedge clk);
    chk("en_abort_we", we_cnt, 0);
    chk("en_abort_flags", {parity_err_o, frame_err_o, overrun_o}, 3'b000);

    // Reset in the middle of DATA, then a clean frame.
    we_cnt = 0;
    wq.delete();
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", data_o, 8'h00);
    chk("mid_rst_we", we_o, 0);
    chk("mid_rst_flags", {parity_err_o, frame_err_o, overrun_o}, 3'b000);
    chk("mid_rst_state", dut.state_q, IDLE);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'hC3, 1'b1, 1'b1);
    repeat (32) @(negedge clk);
    chk("post_rst_we", we_cnt, 1);
    if (wq.size() == 1) chk("post_rst_data", wq[0], 8'hC3);
    chk("post_rst_flags", {parity_err_o, frame_err_o, overrun_o}, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
